dp_control_unit: RTL and testbench

// - Fetch/decode/execute sequencer for ARM data-processing instructions.
// - Sits directly upstream of RegisterFile and ARM_ALU and drives their control inputs:

---
 rtl/dp_control_unit_pkg.sv | 37 +++
 rtl/dp_control_unit_if.sv | 10 +
 rtl/dp_control_unit_cond_check.sv | 35 +++
 rtl/dp_control_unit.sv | 150 +++++++++++++++
 tb/tb_dp_control_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_control_unit_pkg.sv
// Shared definitions for the data-processing control unit: FSM states, ARM opcodes,
// condition codes, RSLCT field offsets and default parameters.
package dp_control_unit_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_WAIT_MFC,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_PC_INC
   } state_t;

   typedef enum logic [3:0] {
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
      OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
   } opcode_t;

   typedef enum logic [3:0] {
      COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } cond_t;

   localparam int RSLCT_RN_LSB = 0;
   localparam int RSLCT_RM_LSB = 4;
   localparam int RSLCT_RS_LSB = 8;
   localparam int RSLCT_RD_LSB = 12;

   localparam int PC_STEP_DEFAULT     = 4;
   localparam int MFC_TIMEOUT_DEFAULT = 15;

   // Flag-only opcodes: they always update NZCV and never write Rd.
   function automatic logic is_compare(input logic [3:0] op);
      return (op >= OP_TST) && (op <= OP_CMN);
   endfunction

endpackage

// File: rtl/dp_control_unit_if.sv
// Instruction-fetch memory port: MFA/MFC request-complete handshake plus address and data.
interface dp_control_unit_if;
   logic        MFA;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_DATA;
   logic        MFC;

   modport master (output MFA, MEM_ADDR, input MEM_DATA, MFC);
   modport slave  (input MFA, MEM_ADDR, output MEM_DATA, MFC);
endinterface

// File: rtl/dp_control_unit_cond_check.sv
// ARM condition-code evaluation: decides whether an instruction executes given NZCV.
module dp_control_unit_cond_check
   import dp_control_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       cond_ok
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = z;
         COND_NE: cond_ok = ~z;
         COND_CS: cond_ok = c;
         COND_CC: cond_ok = ~c;
         COND_MI: cond_ok = n;
         COND_PL: cond_ok = ~n;
         COND_VS: cond_ok = v;
         COND_VC: cond_ok = ~v;
         COND_HI: cond_ok = c & ~z;
         COND_LS: cond_ok = ~c | z;
         COND_GE: cond_ok = (n == v);
         COND_LT: cond_ok = (n != v);
         COND_GT: cond_ok = ~z & (n == v);
         COND_LE: cond_ok = z | (n != v);
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/dp_control_unit.sv
// Fetch/decode/execute sequencer for ARM data-processing instructions; drives RegisterFile and ALU controls.
//
// state        | meaning
// ST_FETCH     | request fetch at PCout, arm timeout counter
// ST_WAIT_MFC  | hold MFA until MFC (capture IR) or timeout (flag error, skip)
// ST_DECODE    | check condition and instruction class
// ST_EXECUTE   | drive sources/opcode to ALU, capture flags if S
// ST_WRITEBACK | write Rd unless a compare opcode
// ST_PC_INC    | write PCout + PC_STEP back to the PC
module dp_control_unit
   import dp_control_unit_pkg::*;
#(
   parameter int PC_STEP     = PC_STEP_DEFAULT,
   parameter int MFC_TIMEOUT = MFC_TIMEOUT_DEFAULT
) (
   input  logic                     Clk,
   input  logic                     RESET,
   dp_control_unit_if.master        mem,
   input  logic [31:0]              PCout,
   input  logic [3:0]               FLAGS_OUT,
   output logic [19:0]              RSLCT,
   output logic                     LOAD,
   output logic                     LOADPC,
   output logic [31:0]              Pcin,
   output logic                     IR_CU,
   output logic [4:0]               OP,
   output logic                     S,
   output logic                     ALU_OUT,
   output logic [3:0]               FLAGS,
   output logic                     FETCH_ERR
);

   localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [31:0]      ir;
   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_done;
   logic             cond_ok, is_dp, is_cmp, s_eff;
   logic [3:0]       opcode;
   logic             mfa, load, loadpc, s_out, alu_out;
   logic [19:0]      rslct;
   logic [4:0]       op;
   logic             unused_ir_bits;

   dp_control_unit_cond_check u_cond_check (
      .cond    (ir[31:28]),
      .nzcv    (FLAGS),
      .cond_ok (cond_ok)
   );

   assign opcode         = ir[24:21];
   assign is_dp          = (ir[27:26] == 2'b00);
   assign is_cmp         = is_compare(opcode);
   assign s_eff          = ir[20] | is_cmp;
   assign tmo_done       = (tmo_cnt == '0);
   assign unused_ir_bits = ^{ir[25], ir[7:4]};

   always_ff @(posedge Clk) begin
      if (RESET) begin
         state     <= ST_FETCH;
         ir        <= '0;
         FLAGS     <= '0;
         FETCH_ERR <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_FETCH:    tmo_cnt <= CNT_W'(MFC_TIMEOUT - 1);
            // MFC on the terminal-count cycle still counts as a good fetch.
            ST_WAIT_MFC: begin
               if (mem.MFC)       ir        <= mem.MEM_DATA;
               else if (tmo_done) FETCH_ERR <= 1'b1;
               else               tmo_cnt   <= tmo_cnt - 1'b1;
            end
            ST_EXECUTE:  if (s_eff) FLAGS <= FLAGS_OUT;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      mfa       = 1'b0;
      load      = 1'b0;
      loadpc    = 1'b0;
      s_out     = 1'b0;
      alu_out   = 1'b0;
      rslct     = '0;
      op        = '0;
      unique case (state)
         ST_FETCH: begin
            mfa       = 1'b1;
            state_nxt = ST_WAIT_MFC;
         end
         ST_WAIT_MFC: begin
            mfa = 1'b1;
            if (mem.MFC)       state_nxt = ST_DECODE;
            else if (tmo_done) state_nxt = ST_PC_INC;
         end
         ST_DECODE: state_nxt = (is_dp && cond_ok) ? ST_EXECUTE : ST_PC_INC;
         ST_EXECUTE: begin
            rslct[RSLCT_RN_LSB +: 4] = ir[19:16];
            rslct[RSLCT_RM_LSB +: 4] = ir[3:0];
            rslct[RSLCT_RS_LSB +: 4] = ir[11:8];
            alu_out   = 1'b1;
            op        = {1'b0, opcode};
            s_out     = s_eff;
            state_nxt = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            rslct[RSLCT_RN_LSB +: 4] = ir[19:16];
            rslct[RSLCT_RM_LSB +: 4] = ir[3:0];
            rslct[RSLCT_RS_LSB +: 4] = ir[11:8];
            rslct[RSLCT_RD_LSB +: 4] = ir[15:12];
            load      = ~is_cmp;
            alu_out   = 1'b1;
            op        = {1'b0, opcode};
            state_nxt = ST_PC_INC;
         end
         ST_PC_INC: begin
            loadpc    = 1'b1;
            state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_FETCH;
      endcase
      // Reset suppresses every strobe immediately so an in-flight write is dropped.
      if (RESET) begin
         mfa     = 1'b0;
         load    = 1'b0;
         loadpc  = 1'b0;
         s_out   = 1'b0;
         alu_out = 1'b0;
         rslct   = '0;
         op      = '0;
      end
   end

   assign mem.MFA      = mfa;
   assign mem.MEM_ADDR = PCout;
   assign RSLCT        = rslct;
   assign LOAD         = load;
   assign LOADPC       = loadpc;
   assign Pcin         = PCout + 32'(PC_STEP);
   assign IR_CU        = 1'b1;
   assign OP           = op;
   assign S            = s_out;
   assign ALU_OUT      = alu_out;

endmodule

// File: tb/tb_dp_control_unit.sv
// Directed plus randomized bench for dp_control_unit with a RegisterFile/ALU stand-in
// and an instruction-level reference model.
module tb_dp_control_unit;

   logic        Clk;
   logic        RESET;
   logic [31:0] PCout;
   logic [3:0]  FLAGS_OUT;
   logic [19:0] RSLCT;
   logic        LOAD, LOADPC;
   logic [31:0] Pcin;
   logic        IR_CU;
   logic [4:0]  OP;
   logic        S, ALU_OUT;
   logic [3:0]  FLAGS;
   logic        FETCH_ERR;

   dp_control_unit_if mem_bus ();

   dp_control_unit dut (
      .Clk       (Clk),
      .RESET     (RESET),
      .mem       (mem_bus),
      .PCout     (PCout),
      .FLAGS_OUT (FLAGS_OUT),
      .RSLCT     (RSLCT),
      .LOAD      (LOAD),
      .LOADPC    (LOADPC),
      .Pcin      (Pcin),
      .IR_CU     (IR_CU),
      .OP        (OP),
      .S         (S),
      .ALU_OUT   (ALU_OUT),
      .FLAGS     (FLAGS),
      .FETCH_ERR (FETCH_ERR)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Environment: register file contents and PC owned by the bench.
   logic [31:0] regs [16];
   logic [31:0] pc;
   logic [35:0] alu_word;

   // Reference model state.
   logic [31:0] m_regs [16];
   logic [3:0]  m_flags;
   logic        m_err;
   logic [31:0] m_pc;

   int n_checks = 0;
   int n_pass   = 0;

   // Operand2 is taken straight from Rm; returns {N,Z,C,V,result}.
   function automatic logic [35:0] alu(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [3:0] f);
      logic [31:0] x, y, r;
      logic [32:0] w;
      logic        cin, c, v, arith;
      c = f[1]; v = f[0]; r = '0; arith = 1'b1;
      x = a; y = b; cin = 1'b0;
      case (op)
         4'd2, 4'd10: begin y = ~b; cin = 1'b1; end
         4'd3:        begin x = b; y = ~a; cin = 1'b1; end
         4'd4, 4'd11: ;
         4'd5:        cin = f[1];
         4'd6:        begin y = ~b; cin = f[1]; end
         4'd7:        begin x = b; y = ~a; cin = f[1]; end
         default:     arith = 1'b0;
      endcase
      w = {1'b0, x} + {1'b0, y} + {32'd0, cin};
      if (arith) begin
         r = w[31:0];
         c = w[32];
         v = (x[31] == y[31]) && (r[31] != x[31]);
      end else begin
         case (op)
            4'd0, 4'd8: r = a & b;
            4'd1, 4'd9: r = a ^ b;
            4'd12:      r = a | b;
            4'd13:      r = b;
            4'd14:      r = a & ~b;
            default:    r = ~b;
         endcase
      end
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
      bit n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb alu_word = alu(OP[3:0], regs[RSLCT[3:0]], regs[RSLCT[7:4]], FLAGS);
   assign FLAGS_OUT = alu_word[35:32];
   assign PCout     = pc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
   // dly = number of WAIT_MFC cycles with MFC low before MFC is raised (>= 15 means never).
   task automatic run_instr(input logic [31:0] ins, input int dly);
      int          cyc, n_load, n_alu, n_mfa, n_ovl, exp_cyc, exp_mfa, n_bad;
      bit          timeout, exec, cmp, done;
      logic [3:0]  op4, ld_rd;
      logic [4:0]  ex_op;
      logic        ex_s;
      logic [11:0] ex_sel;
      logic [31:0] fetch_addr, start_pc;
      logic [35:0] w;

      op4      = ins[24:21];
      cmp      = (op4 >= 4'd8) && (op4 <= 4'd11);
      timeout  = (dly >= 15);
      start_pc = m_pc;
      if (timeout) begin
         exec    = 1'b0;
         m_err   = 1'b1;
         exp_cyc = 17;
         exp_mfa = 16;
      end else begin
         exec    = (ins[27:26] == 2'b00) && cond_holds(ins[31:28], m_flags);
         exp_cyc = dly + (exec ? 6 : 4);
         exp_mfa = dly + 2;
      end
      if (exec) begin
         w = alu(op4, m_regs[ins[19:16]], m_regs[ins[3:0]], m_flags);
         if (ins[20] || cmp) m_flags = w[35:32];
         if (!cmp) m_regs[ins[15:12]] = w[31:0];
      end
      m_pc = m_pc + 32'd4;

      cyc = -1; n_load = 0; n_alu = 0; n_mfa = 0; n_ovl = 0; done = 1'b0;
      ld_rd = 'x; ex_op = 'x; ex_s = 'x; ex_sel = 'x;
      fetch_addr = mem_bus.MEM_ADDR;
      for (int c = 0; c < 40 && !done; c++) begin
         if (mem_bus.MFA) n_mfa++;
         if (LOAD && LOADPC) n_ovl++;
         if (ALU_OUT) begin
            if (n_alu == 0) begin ex_op = OP; ex_s = S; ex_sel = RSLCT[11:0]; end
            n_alu++;
         end
         if (LOAD) begin
            n_load++;
            ld_rd = RSLCT[15:12];
            regs[RSLCT[15:12]] = alu_word[31:0];
         end
         if (LOADPC) begin
            pc   = Pcin;
            done = 1'b1;
            cyc  = c + 1;
         end
         mem_bus.MFC      = !done && (c >= 1) && (c - 1 == dly);
         mem_bus.MEM_DATA = mem_bus.MFC ? ins : $urandom();
         @(negedge Clk);
      end
      mem_bus.MFC = 1'b0;

      n_bad = 0;
      for (int i = 0; i < 16; i++) if (regs[i] !== m_regs[i]) n_bad++;
      check("cycles",     cyc,        exp_cyc);
      check("mfa_cycles", n_mfa,      exp_mfa);
      check("fetch_addr", fetch_addr, start_pc);
      check("load_cnt",   n_load,     (exec && !cmp) ? 1 : 0);
      check("ld_overlap", n_ovl,      0);
      check("regfile",    n_bad,      0);
      check("pc",         PCout,      m_pc);
      check("flags",      FLAGS,      m_flags);
      check("fetch_err",  FETCH_ERR,  m_err);
      check("alu_cycles", n_alu,      exec ? 2 : 0);
      if (exec) begin
         check("op",     ex_op,  {1'b0, op4});
         check("s_bit",  ex_s,   ins[20] | cmp);
         check("src_sel", ex_sel, {ins[11:8], ins[3:0], ins[19:16]});
         if (!cmp) check("rd_sel", ld_rd, ins[15:12]);
      end
   endtask

   logic [31:0] r_ins;
   logic [3:0]  r_op;
   int          r_dly;

   initial begin
      RESET = 1'b1;
      mem_bus.MFC = 1'b0;
      mem_bus.MEM_DATA = '0;
      pc = '0;
      for (int i = 0; i < 16; i++) begin
         regs[i] = $urandom();
      end
      regs[2] = 32'd5;
      regs[3] = 32'd7;
      for (int i = 0; i < 16; i++) m_regs[i] = regs[i];
      m_flags = '0; m_err = 1'b0; m_pc = '0;

      repeat (3) @(negedge Clk);
      check("rst_mfa",    mem_bus.MFA, 1'b0);
      check("rst_load",   LOAD,        1'b0);
      check("rst_loadpc", LOADPC,      1'b0);
      check("rst_s",      S,           1'b0);
      check("rst_aluout", ALU_OUT,     1'b0);
      check("rst_rslct",  RSLCT,       20'd0);
      check("rst_op",     OP,          5'd0);
      check("rst_ir_cu",  IR_CU,       1'b1);
      check("rst_flags",  FLAGS,       4'd0);
      check("rst_err",    FETCH_ERR,   1'b0);
      RESET = 1'b0;
      #1;

      run_instr(32'hE092_1003, 2);             // ADDS R1,R2,R3
      check("adds_r1",    regs[1], 32'd12);
      check("adds_flags", FLAGS,   4'b0000);
      check("adds_pc",    PCout,   32'd4);
      run_instr(32'hE151_0001, 0);             // CMP R1,R1
      check("cmp_flags",  FLAGS,   4'b0110);
      run_instr(32'h11A0_4005, 1);             // MOVNE R4,R5 with Z=1: skipped
      run_instr(32'hE092_1003, 15);            // MFC never arrives
      check("timeout_err", FETCH_ERR, 1'b1);
      run_instr(32'hE1A0_7002, 14);            // MFC on the terminal-count cycle

      for (int k = 0; k < 24; k++) begin
         do r_op = 4'($urandom_range(0, 15)); while (r_op inside {4'd5, 4'd6, 4'd7});
         r_ins = $urandom();
         r_ins[24:21] = r_op;
         r_ins[15:12] = 4'($urandom_range(0, 14));
         r_ins[27:26] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if ($urandom_range(0, 2) == 0) r_ins[31:28] = 4'hE;
         r_dly = ($urandom_range(0, 9) == 0) ? 15 + $urandom_range(0, 3) : $urandom_range(0, 4);
         run_instr(r_ins, r_dly);
      end

      pc = 32'hFFFF_FFFC;
      m_pc = 32'hFFFF_FFFC;
      #1;
      run_instr(32'hE1A0_8003, 0);             // MOV R8,R3 at the top of memory
      check("pc_wrap", PCout, 32'd0);

      run_instr(32'hE151_0001, 0);             // CMP R1,R1 leaves Z,C set
      // ADD R6,R2,R3 interrupted by reset during WRITEBACK.
      mem_bus.MFC = 1'b0;
      @(negedge Clk);
      mem_bus.MFC = 1'b1;
      mem_bus.MEM_DATA = 32'hE082_6003;
      @(negedge Clk);
      mem_bus.MFC = 1'b0;
      repeat (2) @(negedge Clk);
      check("wb_load", LOAD, 1'b1);
      RESET = 1'b1;
      #1;
      check("rst_drops_load", LOAD, 1'b0);
      @(negedge Clk);
      check("midrst_load",   LOAD,      1'b0);
      check("midrst_loadpc", LOADPC,    1'b0);
      check("midrst_mfa",    mem_bus.MFA, 1'b0);
      check("midrst_flags",  FLAGS,     4'd0);
      check("midrst_err",    FETCH_ERR, 1'b0);
      check("midrst_aluout", ALU_OUT,   1'b0);
      RESET = 1'b0;
      m_flags = '0;
      m_err = 1'b0;
      #1;
      check("fetch_after_rst", mem_bus.MFA, 1'b1);
      run_instr(32'hE092_9003, 1);             // ADDS R9,R2,R3 after reset

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
